booth_seq_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 23 ++
 rtl/booth_r4_encoder.sv | 26 ++
 rtl/booth_seq_multiplier.sv | 109 ++++++++++
 tb/tb_booth_seq_multiplier.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Booth operation encoded as {neg, one, two}.
    typedef logic [2:0] booth_op_t;

    localparam booth_op_t BoothZero = 3'b000;
    localparam booth_op_t BoothPos1 = 3'b010;
    localparam booth_op_t BoothPos2 = 3'b001;
    localparam booth_op_t BoothNeg1 = 3'b110;
    localparam booth_op_t BoothNeg2 = 3'b101;

    function automatic int unsigned iter_count(int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps {q1, q0, q-1} to a signed multiple of the multiplicand.
module booth_r4_encoder
    import mult_pkg::*;
(
    input  logic [2:0] bits_i,
    output logic       neg_o,
    output logic       one_o,
    output logic       two_o
);

    booth_op_t op;

    always_comb begin
        op = BoothZero;
        unique case (bits_i)
            3'b001, 3'b010: op = BoothPos1;
            3'b011:         op = BoothPos2;
            3'b100:         op = BoothNeg2;
            3'b101, 3'b110: op = BoothNeg1;
            default:        op = BoothZero;
        endcase
    end

    assign {neg_o, one_o, two_o} = op;

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one add/shift step per cycle, start/done handshake,
// per-operation signed or unsigned operands.
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   Ra,
    input  logic [WIDTH-1:0]   Rb,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Rz
);

    localparam int unsigned ExtW    = WIDTH + 2;
    localparam int unsigned NumIter = iter_count(WIDTH);
    localparam int unsigned CntW    = $clog2(NumIter + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(NumIter - 1);

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q;
    logic [ExtW-1:0]    m_q, p_q, q_q;
    logic               qm1_q;
    logic [2*WIDTH-1:0] rz_q;

    logic            neg, one, two;
    logic            start_accept;
    logic [ExtW:0]   p_ext, m_ext, addend, sum;
    logic [ExtW-1:0] p_nxt, q_nxt;
    logic            qm1_nxt;

    booth_r4_encoder u_encoder (
        .bits_i ({q_q[1:0], qm1_q}),
        .neg_o  (neg),
        .one_o  (one),
        .two_o  (two)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    assign start_accept = start && (state_q != StRun);

    // One extra bit keeps the sign when adding +-2M to the partial product.
    always_comb begin
        p_ext   = {p_q[ExtW-1], p_q};
        m_ext   = {m_q[ExtW-1], m_q};
        addend  = two ? {m_q, 1'b0} : (one ? m_ext : '0);
        sum     = neg ? (p_ext - addend) : (p_ext + addend);
        p_nxt   = {sum[ExtW], sum[ExtW:2]};
        q_nxt   = {sum[1:0], q_q[ExtW-1:2]};
        qm1_nxt = q_q[1];
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            cnt_q <= '0;
            m_q   <= '0;
            p_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            rz_q  <= '0;
        end else if (start_accept) begin
            cnt_q <= CntInit;
            m_q   <= {{2{is_signed & Ra[WIDTH-1]}}, Ra};
            p_q   <= '0;
            q_q   <= {{2{is_signed & Rb[WIDTH-1]}}, Rb};
            qm1_q <= 1'b0;
        end else if (state_q == StRun) begin
            p_q   <= p_nxt;
            q_q   <= q_nxt;
            qm1_q <= qm1_nxt;
            if (cnt_q == '0) begin
                rz_q <= {p_nxt[WIDTH-3:0], q_nxt};
            end else begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    assign Rz = rz_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Randomised and directed bench for booth_seq_multiplier at WIDTH = 32, 8 and 4.
module tb_booth_seq_multiplier;

    logic clock;
    logic clear;

    logic        start32, sg32, busy32, done32;
    logic [31:0] ra32, rb32;
    logic [63:0] rz32;
    logic        start8, sg8, busy8, done8;
    logic [7:0]  ra8, rb8;
    logic [15:0] rz8;
    logic        start4, sg4, busy4, done4;
    logic [3:0]  ra4, rb4;
    logic [7:0]  rz4;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[7] = '{
        '{32'h0000000F, 32'h0000000A, 1'b1, 64'h0000000000000096},
        '{32'h0000000F, 32'hFFFFFFF6, 1'b1, 64'hFFFFFFFFFFFFFF6A},
        '{32'hFFFFFFF1, 32'hFFFFFFF6, 1'b1, 64'h0000000000000096},
        '{32'h00000000, 32'h0000000A, 1'b1, 64'h0000000000000000},
        '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001}
    };

    booth_seq_multiplier #(.WIDTH(32)) u_dut32 (
        .clock(clock), .clear(clear), .start(start32), .is_signed(sg32),
        .Ra(ra32), .Rb(rb32), .busy(busy32), .done(done32), .Rz(rz32)
    );
    booth_seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clock(clock), .clear(clear), .start(start8), .is_signed(sg8),
        .Ra(ra8), .Rb(rb8), .busy(busy8), .done(done8), .Rz(rz8)
    );
    booth_seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clock(clock), .clear(clear), .start(start4), .is_signed(sg4),
        .Ra(ra4), .Rb(rb4), .busy(busy4), .done(done4), .Rz(rz4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Exact product as plain arithmetic, reduced to 2*w bits.
    function automatic logic [63:0] ref_prod(logic [63:0] a, logic [63:0] b, int w, bit s);
        logic [63:0] sa, sb, p;
        sa = a;
        sb = b;
        if (s && a[w-1]) sa = a | (~64'h0 << w);
        if (s && b[w-1]) sb = b | (~64'h0 << w);
        p = sa * sb;
        if (w < 32) p = p & ((64'h1 << (2 * w)) - 64'h1);
        return p;
    endfunction

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit s,
                        output logic [63:0] r, output int lat);
        ra32 = a; rb32 = b; sg32 = s; start32 = 1'b1;
        @(posedge clock); #1 start32 = 1'b0;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            lat++;
            if (done32) break;
        end
        if (!done32) lat = -1;
        r = rz32;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       output logic [15:0] r, output int lat);
        ra8 = a; rb8 = b; sg8 = s; start8 = 1'b1;
        @(posedge clock); #1 start8 = 1'b0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            lat++;
            if (done8) break;
        end
        if (!done8) lat = -1;
        r = rz8;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s,
                       output logic [7:0] r, output int lat);
        ra4 = a; rb4 = b; sg4 = s; start4 = 1'b1;
        @(posedge clock); #1 start4 = 1'b0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            lat++;
            if (done4) break;
        end
        if (!done4) lat = -1;
        r = rz4;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy32); end
        total++; if (done32 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done32); end
        total++; if (rz32 !== 64'h0) begin bad++; $display("FAIL reset_rz32 got=%h want=0", rz32); end
        total++; if (rz8 !== 16'h0 || busy8 !== 1'b0) begin bad++; $display("FAIL reset_w8 rz=%h busy=%b want 0", rz8, busy8); end
        total++; if (rz4 !== 8'h0 || busy4 !== 1'b0) begin bad++; $display("FAIL reset_w4 rz=%h busy=%b want 0", rz4, busy4); end
        clear = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        logic [63:0] r;
        int lat;
        foreach (vecs[k]) begin
            op32(vecs[k].a, vecs[k].b, vecs[k].s, r, lat);
            total++;
            if (r !== vecs[k].p) begin
                bad++;
                $display("FAIL directed_%0d got=%h want=%h", k, r, vecs[k].p);
            end
            total++;
            if (lat != 17) begin bad++; $display("FAIL directed_lat_%0d got=%0d want=17", k, lat); end
        end
    endtask

    task automatic test_random32();
        logic [63:0] r, exp;
        logic [31:0] a, b;
        int lat;
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            op32(a, b, k[0], r, lat);
            exp = ref_prod(64'(a), 64'(b), 32, k[0]);
            total++;
            if (r !== exp || lat != 17) begin
                bad++;
                $display("FAIL random32 a=%h b=%h s=%0d got=%h lat=%0d want=%h lat=17",
                         a, b, k[0], r, lat, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r1;
        logic [31:0] a2, b2;
        int lat, gap;
        a2 = $urandom;
        b2 = $urandom;
        op32(32'h12345678, 32'h9ABCDEF0, 1'b0, r1, lat);
        total++;
        if (r1 !== ref_prod(64'h12345678, 64'h9ABCDEF0, 32, 1'b0)) begin
            bad++; $display("FAIL b2b_first got=%h", r1);
        end
        // Start is raised while done is still high.
        ra32 = a2; rb32 = b2; sg32 = 1'b1; start32 = 1'b1;
        @(posedge clock); #1 start32 = 1'b0;
        gap = 1;
        total++;
        if (done32 !== 1'b0 || busy32 !== 1'b1 || rz32 !== r1) begin
            bad++; $display("FAIL b2b_relaunch done=%b busy=%b rz=%h want 0 1 %h", done32, busy32, rz32, r1);
        end
        for (int i = 0; i < 40 && !done32; i++) begin
            @(posedge clock); #1;
            gap++;
        end
        total++;
        if (gap != 18) begin bad++; $display("FAIL b2b_gap got=%0d want=18", gap); end
        total++;
        if (rz32 !== ref_prod(64'(a2), 64'(b2), 32, 1'b1)) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", rz32, ref_prod(64'(a2), 64'(b2), 32, 1'b1));
        end
        @(posedge clock); #1;
        total++;
        if (done32 !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b want=0", done32); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] a, b;
        logic [63:0] exp;
        int lat, extra;
        a = $urandom | 32'h80000001;
        b = $urandom;
        exp = ref_prod(64'(a), 64'(b), 32, 1'b1);
        ra32 = a; rb32 = b; sg32 = 1'b1; start32 = 1'b1;
        @(posedge clock); #1 start32 = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clock); #1 lat++; end
        ra32 = ~a; rb32 = b ^ 32'h5A5A5A5A; sg32 = 1'b0; start32 = 1'b1;
        @(posedge clock); #1 lat++;
        start32 = 1'b0;
        for (int i = 0; i < 40 && !done32; i++) begin
            @(posedge clock); #1 lat++;
        end
        total++;
        if (lat != 17) begin bad++; $display("FAIL ignore_lat got=%0d want=17", lat); end
        total++;
        if (rz32 !== exp) begin bad++; $display("FAIL ignore_result got=%h want=%h", rz32, exp); end
        extra = 0;
        repeat (25) begin @(posedge clock); #1 if (done32) extra++; end
        total++;
        if (extra != 0) begin bad++; $display("FAIL ignore_queued got=%0d dones want=0", extra); end
    endtask

    task automatic test_abort();
        logic [63:0] r;
        int lat, seen;
        op32(32'd3, 32'd5, 1'b0, r, lat);
        total++;
        if (r !== 64'd15) begin bad++; $display("FAIL abort_pre got=%h want=f", r); end
        ra32 = 32'hDEADBEEF; rb32 = 32'h01234567; sg32 = 1'b1; start32 = 1'b1;
        @(posedge clock); #1 start32 = 1'b0;
        repeat (7) @(posedge clock);
        #1 clear = 1'b0;
        @(posedge clock); #1;
        total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy32); end
        total++; if (done32 !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done32); end
        total++; if (rz32 !== 64'h0) begin bad++; $display("FAIL abort_rz got=%h want=0", rz32); end
        clear = 1'b1;
        seen = 0;
        repeat (30) begin @(posedge clock); #1 if (done32 || busy32) seen++; end
        total++;
        if (seen != 0) begin bad++; $display("FAIL abort_late_done got=%0d want=0", seen); end
    endtask

    task automatic test_sweep4();
        logic [7:0] r;
        logic [63:0] exp;
        int lat;
        op4(4'h8, 4'h7, 1'b1, r, lat);
        total++;
        if (r !== 8'hC8 || lat != 3) begin bad++; $display("FAIL w4_s87 got=%h lat=%0d want=c8 lat=3", r, lat); end
        op4(4'hF, 4'hF, 1'b0, r, lat);
        total++;
        if (r !== 8'hE1 || lat != 3) begin bad++; $display("FAIL w4_uff got=%h lat=%0d want=e1 lat=3", r, lat); end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    op4(4'(i), 4'(j), s[0], r, lat);
                    exp = ref_prod(64'(i), 64'(j), 4, s[0]);
                    total++;
                    if (64'(r) !== exp || lat != 3) begin
                        bad++;
                        $display("FAIL w4_sweep a=%h b=%h s=%0d got=%h lat=%0d want=%h",
                                 i, j, s, r, lat, exp[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_sweep8();
        logic [15:0] r;
        logic [63:0] exp;
        logic [7:0] a, b;
        logic [7:0] corner[5];
        int lat;
        corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        for (int s = 0; s < 2; s++) begin
            foreach (corner[i]) begin
                foreach (corner[j]) begin
                    op8(corner[i], corner[j], s[0], r, lat);
                    exp = ref_prod(64'(corner[i]), 64'(corner[j]), 8, s[0]);
                    total++;
                    if (64'(r) !== exp || lat != 5) begin
                        bad++;
                        $display("FAIL w8_corner a=%h b=%h s=%0d got=%h lat=%0d want=%h",
                                 corner[i], corner[j], s, r, lat, exp[15:0]);
                    end
                end
            end
        end
        for (int k = 0; k < 2000; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op8(a, b, k[0], r, lat);
            exp = ref_prod(64'(a), 64'(b), 8, k[0]);
            total++;
            if (64'(r) !== exp || lat != 5) begin
                bad++;
                $display("FAIL w8_random a=%h b=%h s=%0d got=%h lat=%0d want=%h",
                         a, b, k[0], r, lat, exp[15:0]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        clear = 1'b0;
        start32 = 1'b0; sg32 = 1'b0; ra32 = '0; rb32 = '0;
        start8 = 1'b0;  sg8 = 1'b0;  ra8 = '0;  rb8 = '0;
        start4 = 1'b0;  sg4 = 1'b0;  ra4 = '0;  rb4 = '0;
        test_reset();
        test_directed();
        test_random32();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_sweep4();
        test_sweep8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
